// File: rtl/ps_readout_arbiter.sv
// Round-robin arbiter that merges per-channel ADC capture streams onto the single
// PS return stream, prefixing each granted packet with a channel/sequence header.
module ps_readout_arbiter #(
  parameter int NUM_CH    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     busy,
  output logic [3:0]               active_ch
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state, state_nxt;
  logic [3:0]          grant;
  logic [3:0]          last_grant;
  logic [3:0]          req_idx;
  logic                req_found;
  logic [NUM_CH-1:0]   req;
  logic [CNT_W-1:0]    cnt;
  logic [15:0]         seq [NUM_CH];
  logic [NUM_CH-1:0]   cont;
  logic [DATA_W-1:0]   hdr_word;
  logic                at_cap;
  logic                xfer;

  function automatic logic [DATA_W-1:0] make_header(input logic       cont_bit,
                                                     input logic [3:0] ch,
                                                     input logic [15:0] sq);
    return {8'hA5, cont_bit, 3'b000, ch, sq};
  endfunction

  assign req       = s_tvalid & ch_enable;
  assign active_ch = grant;

  // Rotating priority: the search begins just after the channel granted last.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!req_found && req[(int'(last_grant) + k) % NUM_CH]) begin
        req_found = 1'b1;
        req_idx   = 4'((int'(last_grant) + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_tready  = '0;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    at_cap    = (cnt == CNT_W'(MAX_BURST - 1));
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (req_found) state_nxt = HDR;
      end
      HDR: begin
        m_tdata  = hdr_word;
        m_tvalid = 1'b1;
        if (m_tready) state_nxt = DATA;
      end
      DATA: begin
        // Zero-latency pass-through of the granted channel.
        m_tdata         = s_tdata[int'(grant)*DATA_W +: DATA_W];
        m_tvalid        = s_tvalid[grant];
        m_tlast         = s_tlast[grant] | at_cap;
        s_tready[grant] = m_tready;
        xfer            = s_tvalid[grant] & m_tready;
        if (xfer && m_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      last_grant <= 4'(NUM_CH - 1);
      cnt        <= '0;
      cont       <= '0;
      hdr_word   <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            grant    <= req_idx;
            hdr_word <= make_header(cont[req_idx], req_idx, seq[req_idx]);
            busy     <= 1'b1;
          end
        end
        HDR: begin
          if (m_tready) begin
            seq[grant] <= seq[grant] + 16'd1;
            cnt        <= '0;
            hdr_word   <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            cnt <= cnt + 1'b1;
            if (m_tlast) begin
              // A packet cut by the burst cap is flagged so the PS can stitch it.
              last_grant  <= grant;
              cont[grant] <= at_cap & ~s_tlast[grant];
              grant       <= '0;
              busy        <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_readout_arbiter.sv
// Directed bench for ps_readout_arbiter: per-channel sources, a spec-level
// cycle model compared every cycle, a word scoreboard and literal header checks.
`timescale 1ns/1ps
module tb_ps_readout_arbiter;

  localparam int NUM_CH    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH-1:0]        s_tready;
  logic [DATA_W-1:0]        m_tdata;
  logic                     m_tvalid;
  logic                     m_tlast;
  logic                     m_tready;
  logic                     busy;
  logic [3:0]               active_ch;

  ps_readout_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tready_mode = 0;

  logic [32:0] src_q [NUM_CH][$];
  logic [31:0] sb_q  [NUM_CH][$];
  logic [33:0] log_q [$];
  logic        saw_rdy1;

  // Model state: phase 0 = no grant, 1 = header owed, 2 = data of mdl_ch.
  int          mdl_ph, mdl_ch, mdl_cnt, mdl_last;
  logic [15:0] mdl_seq  [NUM_CH];
  logic        mdl_cont [NUM_CH];
  logic [NUM_CH-1:0] cap_req, cap_hs;
  logic        cap_xfer, cap_end, cap_capped, cap_tlast;
  logic        prev_stall;
  logic [DATA_W-1:0] prev_data;

  task automatic model_reset();
    mdl_ph = 0; mdl_ch = 0; mdl_cnt = 0; mdl_last = NUM_CH - 1;
    for (int i = 0; i < NUM_CH; i++) begin mdl_seq[i] = '0; mdl_cont[i] = 1'b0; end
    cap_req = '0; cap_hs = '0; cap_xfer = 0; cap_end = 0; cap_capped = 0; cap_tlast = 0;
    prev_stall = 0;
  endtask

  task automatic check_cycle();
    logic [DATA_W-1:0] e_data;
    logic              e_valid, e_last, e_busy;
    logic [3:0]        e_ch;
    logic [NUM_CH-1:0] e_rdy;
    logic [31:0]       exp_w;
    e_data = '0; e_valid = 0; e_last = 0; e_busy = 0; e_ch = '0; e_rdy = '0;
    if (!rst) model_reset();
    if (mdl_ph == 1) begin
      e_valid = 1; e_busy = 1; e_ch = 4'(mdl_ch);
      e_data  = {8'hA5, mdl_cont[mdl_ch], 3'b000, 4'(mdl_ch), mdl_seq[mdl_ch]};
    end else if (mdl_ph == 2) begin
      e_busy = 1; e_ch = 4'(mdl_ch);
      e_data = s_tdata[mdl_ch*DATA_W +: DATA_W];
      e_valid = s_tvalid[mdl_ch];
      e_last = s_tlast[mdl_ch] || (mdl_cnt == MAX_BURST - 1);
      e_rdy[mdl_ch] = m_tready;
    end
    tests++;
    if ({m_tvalid, m_tlast, busy, active_ch, s_tready} !== {e_valid, e_last, e_busy, e_ch, e_rdy}) begin
      fails++;
      $display("FAIL ctl @%0t: got v=%b l=%b busy=%b ch=%0d rdy=%h, expected v=%b l=%b busy=%b ch=%0d rdy=%h",
               $time, m_tvalid, m_tlast, busy, active_ch, s_tready, e_valid, e_last, e_busy, e_ch, e_rdy);
    end
    tests++;
    if (m_tdata !== e_data) begin
      fails++;
      $display("FAIL tdata @%0t: got %h expected %h", $time, m_tdata, e_data);
    end
    if (rst && prev_stall) begin
      tests++;
      if (!(m_tvalid && m_tdata == prev_data)) begin
        fails++;
        $display("FAIL stall_hold @%0t: got v=%b d=%h expected v=1 d=%h", $time, m_tvalid, m_tdata, prev_data);
      end
    end
    prev_stall = rst && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    if (s_tready[1]) saw_rdy1 = 1'b1;
    cap_xfer   = e_valid && m_tready;
    cap_end    = cap_xfer && e_last;
    cap_capped = (mdl_cnt == MAX_BURST - 1);
    cap_tlast  = (mdl_ph == 2) ? s_tlast[mdl_ch] : 1'b0;
    cap_req    = s_tvalid & ch_enable;
    cap_hs     = s_tvalid & s_tready;
    if (rst && cap_xfer) log_q.push_back({mdl_ph == 1, m_tlast, m_tdata});
    if (rst && cap_xfer && mdl_ph == 2) begin
      tests++;
      if (sb_q[mdl_ch].size() == 0) begin
        fails++;
        $display("FAIL scoreboard ch%0d: got %h with nothing outstanding", mdl_ch, m_tdata);
      end else begin
        exp_w = sb_q[mdl_ch].pop_front();
        if (m_tdata !== exp_w) begin
          fails++;
          $display("FAIL scoreboard ch%0d: got %h expected %h", mdl_ch, m_tdata, exp_w);
        end
      end
    end
  endtask

  task automatic advance_model();
    logic found;
    int   c;
    found = 0;
    if (mdl_ph == 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (mdl_last + k) % NUM_CH;
        if (!found && cap_req[c]) begin found = 1; mdl_ch = c; mdl_ph = 1; end
      end
    end else if (mdl_ph == 1) begin
      if (cap_xfer) begin mdl_seq[mdl_ch] = mdl_seq[mdl_ch] + 16'd1; mdl_cnt = 0; mdl_ph = 2; end
    end else if (cap_xfer) begin
      mdl_cnt++;
      if (cap_end) begin
        mdl_cont[mdl_ch] = cap_capped && !cap_tlast;
        mdl_last = mdl_ch;
        mdl_ph = 0;
      end
    end
  endtask

  // Model / compare process: check at negedge, advance just after posedge.
  initial begin
    model_reset();
    saw_rdy1 = 0;
    forever begin
      @(negedge clk);
      check_cycle();
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++)
        if (cap_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (rst) advance_model(); else model_reset();
    end
  end

  // Source and sink drivers.
  initial begin
    forever begin
      @(posedge clk); #3;
      for (int i = 0; i < NUM_CH; i++) begin
        if (src_q[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = src_q[i][0][32];
          s_tdata[i*DATA_W +: DATA_W] = src_q[i][0][31:0];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_tdata[i*DATA_W +: DATA_W] = '0;
        end
      end
      m_tready = (tready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic push_pkt(input int ch, input int n, input logic [31:0] base);
    for (int j = 0; j < n; j++) begin
      src_q[ch].push_back({j == n - 1, base + 32'(j)});
      sb_q[ch].push_back(base + 32'(j));
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_CH; i++) begin src_q[i].delete(); sb_q[i].delete(); end
    log_q.delete();
    saw_rdy1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic chans_empty(input logic [NUM_CH-1:0] mask);
    for (int i = 0; i < NUM_CH; i++)
      if (mask[i] && (sb_q[i].size() > 0 || src_q[i].size() > 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input logic [NUM_CH-1:0] mask, input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(mdl_ph == 0 && chans_empty(mask))) begin
      @(posedge clk); #2;
      n++;
    end
    tests++;
    if (n >= budget) begin fails++; $display("FAIL %s: timed out after %0d cycles", name, budget); end
  endtask

  task automatic check_log(input int idx, input logic [33:0] exp, input string name);
    tests++;
    if (idx >= log_q.size()) begin
      fails++;
      $display("FAIL %s: entry %0d missing, log holds %0d", name, idx, log_q.size());
    end else if (log_q[idx] !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, log_q[idx], exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ch_enable = '1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    #1 rst = 1'b0;
    #2;
    tests++;
    if ({m_tvalid, m_tlast, busy, active_ch, s_tready, m_tdata} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b l=%b busy=%b ch=%0d rdy=%h d=%h, expected all 0",
               m_tvalid, m_tlast, busy, active_ch, s_tready, m_tdata);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // 1: single channel, two packets
    do_reset();
    push_pkt(3, 4, 32'h3000_0001);
    wait_done('1, 100, "t1_pkt1");
    push_pkt(3, 4, 32'h3100_0001);
    wait_done('1, 100, "t1_pkt2");
    check_log(0, {2'b10, 32'hA503_0000}, "t1_hdr1");
    check_log(1, {2'b00, 32'h3000_0001}, "t1_word1");
    check_log(4, {2'b01, 32'h3000_0004}, "t1_last");
    check_log(5, {2'b10, 32'hA503_0001}, "t1_hdr2");

    // 2: three channels, round-robin order
    do_reset();
    for (int c = 0; c < 3; c++) begin
      push_pkt(c, 2, 32'h1000_0000 * (c + 1));
      push_pkt(c, 2, 32'h1000_0000 * (c + 1) + 32'h100);
    end
    wait_done('1, 200, "t2_done");
    check_log(0,  {2'b10, 32'hA500_0000}, "t2_hdr0");
    check_log(3,  {2'b10, 32'hA501_0000}, "t2_hdr1");
    check_log(6,  {2'b10, 32'hA502_0000}, "t2_hdr2");
    check_log(9,  {2'b10, 32'hA500_0001}, "t2_hdr3");
    check_log(12, {2'b10, 32'hA501_0001}, "t2_hdr4");
    check_log(15, {2'b10, 32'hA502_0001}, "t2_hdr5");

    // 3: packet longer than the burst cap
    do_reset();
    push_pkt(3, 6, 32'h3300_0001);
    wait_done('1, 100, "t3_split");
    push_pkt(3, 1, 32'h3400_0001);
    wait_done('1, 100, "t3_next");
    check_log(0, {2'b10, 32'hA503_0000}, "t3_hdr1");
    check_log(4, {2'b01, 32'h3300_0004}, "t3_cap_last");
    check_log(5, {2'b10, 32'hA583_0001}, "t3_hdr_cont");
    check_log(7, {2'b01, 32'h3300_0006}, "t3_tail_last");
    check_log(8, {2'b10, 32'hA503_0002}, "t3_hdr_nocont");

    // 4: random back-pressure across several channels
    do_reset();
    tready_mode = 1;
    push_pkt(0, 5, 32'h0A00_0000);
    push_pkt(7, 3, 32'h7A00_0000);
    push_pkt(15, 8, 32'hFA00_0000);
    push_pkt(7, 2, 32'h7B00_0000);
    wait_done('1, 2000, "t4_stalls");
    tready_mode = 0;
    tests++;
    if (!chans_empty('1)) begin fails++; $display("FAIL t4_drain: got words outstanding, expected none"); end

    // 5: masked channel is never served until enabled
    do_reset();
    ch_enable = 16'hFFFD;
    push_pkt(1, 2, 32'h1100_0000);
    push_pkt(2, 2, 32'h2200_0000);
    push_pkt(2, 2, 32'h2300_0000);
    wait_done(16'h0004, 200, "t5_masked");
    tests++;
    if (saw_rdy1) begin fails++; $display("FAIL t5_rdy1: got s_tready[1]=1 while masked, expected 0"); end
    check_log(0, {2'b10, 32'hA502_0000}, "t5_hdr_a");
    check_log(3, {2'b10, 32'hA502_0001}, "t5_hdr_b");
    ch_enable = 16'hFFFF;
    push_pkt(2, 2, 32'h2400_0000);
    wait_done('1, 200, "t5_enabled");
    check_log(6, {2'b10, 32'hA501_0000}, "t5_ch1_wins");
    check_log(9, {2'b10, 32'hA502_0002}, "t5_ch2_after");

    // 6: reset in the middle of a packet
    do_reset();
    push_pkt(5, 4, 32'h5500_0001);
    n = 0;
    while (n < 100 && log_q.size() < 2) begin @(posedge clk); #2; n++; end
    tests++;
    if (n >= 100) begin fails++; $display("FAIL t6_start: timed out waiting for word 1"); end
    rst = 1'b0;
    #1;
    tests++;
    if ({m_tvalid, m_tlast, busy, active_ch, s_tready, m_tdata} !== '0) begin
      fails++;
      $display("FAIL t6_reset_out: got v=%b l=%b busy=%b ch=%0d rdy=%h d=%h, expected all 0",
               m_tvalid, m_tlast, busy, active_ch, s_tready, m_tdata);
    end
    clear_all();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    push_pkt(5, 2, 32'h5600_0001);
    wait_done('1, 100, "t6_after");
    check_log(0, {2'b10, 32'hA505_0000}, "t6_hdr_seq_cleared");
    check_log(2, {2'b01, 32'h5600_0002}, "t6_last");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps_readout_arbiter.md
Name: ps_readout_arbiter

Overview:
- Shares the single 32-bit AXIS return path to the PS among NUM_CH per-channel ADC capture streams.
- Arbitration is round-robin.
- Each granted packet is prefixed with a header word carrying the channel id, a per-channel sequence number and a continuation flag.
- Sits between the per-ADC capture buffers (already reduced to 32-bit words) and the PS-facing master port of the PL controller.

Parameters:
- NUM_CH, 16, number of requesting channels (1..16).
- DATA_W, 32, word width of the input streams and the output stream (fixed 32; header layout depends on it).
- MAX_BURST, 1024, maximum data words per output packet (>=2) before the grant is forcibly released.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ch_enable  in  NUM_CH  per-channel enable mask (driven from GPIO control); sampled only during arbitration.
- s_tdata  in  NUM_CH*DATA_W  channel words; channel i occupies bits [i*32 +: 32].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tlast  in  NUM_CH  per-channel end of capture packet.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_W  stream to PS.
- m_tvalid  out  1  stream valid.
- m_tlast  out  1  end of output packet.
- m_tready  in  1  PS ready.
- busy  out  1  high in HDR or DATA state.
- active_ch  out  4  granted channel; 0 when idle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=all 0, busy=0, active_ch=0.
  - All sequence counters and continuation flags cleared.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
  - Reset mid-packet abandons the packet; there is no recovery.
- State IDLE:
  - Requesters are channels with s_tvalid[i]=1 and ch_enable[i]=1.
  - Search starts at last_grant+1, wraps modulo NUM_CH.
  - First hit is registered as grant g; next state HDR.
  - One-cycle arbitration latency: a request seen at edge N gives header valid after edge N+1.
  - No requester: stay in IDLE.
  - All outputs low, all s_tready low.
- State HDR:
  - m_tvalid=1, m_tlast=0, all s_tready=0.
  - m_tdata = {8'hA5, cont[g], 3'b000, g[3:0], seq[g][15:0]}.
  - On m_tready=1: seq[g] increments (16-bit, wraps FFFF->0000), word counter cnt=0, next state DATA.
  - The header stays stable while m_tready=0.
- State DATA (combinational pass-through of channel g; zero added latency):
  - m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], s_tready[g]=m_tready, every other s_tready=0.
  - m_tlast = s_tlast[g] OR (cnt==MAX_BURST-1).
  - Each transfer (m_tvalid & m_tready) increments cnt.
  - On a transfer with m_tlast=1: last_grant=g; next state IDLE.
  - cont[g] is set to 1 if the packet ended on the cap with s_tlast[g]=0; otherwise cont[g]=0.
  - Cap and s_tlast on the same word gives cont=0.
- A packet is never interrupted:
  - Deasserting ch_enable[g] or s_tvalid[g] mid-packet only stalls output; the grant is held until the m_tlast transfer.
  - The bus idles at least one cycle (IDLE) between packets.
  - The same channel may win consecutively only if no other channel is requesting.
- Registered outputs and state: m_tvalid in HDR, m_tdata in HDR, busy, active_ch (=g in HDR/DATA).
- Combinational outputs: the DATA-state paths listed above.
- AXIS rule: m_tvalid never depends on m_tready.

Test Plan:
1. Only ch3 valid, 4-word packet with s_tlast on word 4, m_tready=1:
   - Output: header 0xA5030000, then the 4 words, m_tlast on word 4.
   - A second ch3 packet gets header 0xA5030001.
2. ch0, ch1 and ch2 each hold 2-word packets continuously valid:
   - Grant order is 0,1,2,0,1,2.
   - Headers 0xA5000000, 0xA5010000, 0xA5020000, then 0xA5000001.
3. MAX_BURST=4, ch3 sends a 6-word packet:
   - Packet 1: header 0xA5030000, 4 words, m_tlast on word 4.
   - Packet 2: header 0xA5830001, 2 words, m_tlast on word 2.
   - Next ch3 header has cont=0.
4. Random m_tready stalls during header and data:
   - m_tdata and m_tvalid are held stable while stalled.
   - Scoreboard sees every input word exactly once, in order.
5. ch_enable=16'hFFFD with ch1 and ch2 valid:
   - s_tready[1] never rises; only ch2 is served.
   - Setting ch_enable=FFFF lets ch1 win at the next arbitration.
6. rst asserted during word 2 of a ch5 packet, then released:
   - Outputs go to 0 immediately and busy=0.
   - After release, ch5 header is 0xA5050000 (seq cleared).
